// File: rtl/jt51_modbuf_if.sv
// Signal bundle between the operator pipeline and jt51_modbuf.
// cen qualifies every field: one slot is transferred per cen cycle, with no backpressure.
`timescale 1ns/1ps
interface jt51_modbuf_if #(
   parameter int W  = 14,
   parameter int MW = 10
);
   logic          cen;
   logic          zero;
   logic [W-1:0]  op_result;
   logic [2:0]    fb_II;
   logic          m1_enters;
   logic          use_prevprev1;
   logic          use_prev2;
   logic          use_prev1;
   logic          use_internal_x;
   logic          use_internal_y;
   logic [MW-1:0] mod_out;
   logic [4:0]    slot;

   modport master (
      output cen, zero, op_result, fb_II, m1_enters,
      output use_prevprev1, use_prev2, use_prev1, use_internal_x, use_internal_y,
      input  mod_out, slot
   );

   modport slave (
      input  cen, zero, op_result, fb_II, m1_enters,
      input  use_prevprev1, use_prev2, use_prev1, use_internal_x, use_internal_y,
      output mod_out, slot
   );
endinterface

// File: rtl/jt51_modbuf.sv
// Operator output history and per-slot phase-modulation builder with M1 self-feedback.
// Optional: define JT51_MODBUF_SAT_EN to saturate the feedback modulation instead of wrapping.
`timescale 1ns/1ps
module jt51_modbuf #(
   parameter int W  = 14,
   parameter int MW = 10
) (
   input logic          clk,
   input logic          rst,
   jt51_modbuf_if.slave bus
);
   localparam int HL = 24;

   logic [4:0]    slot_q, slot_d;
   logic [MW-1:0] mod_q, mod_d;
   logic [W-1:0]  hist_q [HL];
   logic [W-1:0]  hist_d [HL];
   logic [W-1:0]  x_q [8];
   logic [W-1:0]  x_d [8];
   logic [W-1:0]  y_q [8];
   logic [W-1:0]  y_d [8];
   logic [W-1:0]  fb0_q [8];
   logic [W-1:0]  fb0_d [8];
   logic [W-1:0]  fb1_q [8];
   logic [W-1:0]  fb1_d [8];

   logic [4:0]        wr_slot;
   logic [2:0]        wr_ch;
   logic [2:0]        rd_ch;
   logic [W:0]        sum;
   logic [2:0]        n_sel;
   logic [MW-1:0]     sel_mod;
   logic signed [W:0] fbsum;
   logic signed [W:0] fbsh;
   logic [3:0]        fb_shamt;
   logic [MW-1:0]     fb_mod;
   logic [MW-1:0]     mod_next;
   logic              unused_bits;

   // op_result belongs to the slot before the one whose flags are presented.
   assign wr_slot = slot_q - 5'd1;
   assign wr_ch   = wr_slot[2:0];
   assign rd_ch   = slot_q[2:0];

   assign bus.slot    = slot_q;
   assign bus.mod_out = mod_q;

   function automatic logic [W:0] sext(input logic [W-1:0] v);
      return {v[W-1], v};
   endfunction

   // Taps: P1 = 1 slot back, P2 = 8 slots back, PP1 = 16 slots back.
   always_comb begin
      sum   = '0;
      n_sel = '0;
      if (bus.use_prevprev1) begin
         sum   = sum + sext(hist_q[15]);
         n_sel = n_sel + 3'd1;
      end
      if (bus.use_prev2) begin
         sum   = sum + sext(hist_q[7]);
         n_sel = n_sel + 3'd1;
      end
      if (bus.use_prev1) begin
         sum   = sum + sext(hist_q[0]);
         n_sel = n_sel + 3'd1;
      end
      if (bus.use_internal_x) begin
         sum   = sum + sext(x_q[rd_ch]);
         n_sel = n_sel + 3'd1;
      end
      if (bus.use_internal_y) begin
         sum   = sum + sext(y_q[rd_ch]);
         n_sel = n_sel + 3'd1;
      end
      case (n_sel)
         3'd0:    sel_mod = '0;
         3'd1:    sel_mod = sum[W-1:W-MW];
         default: sel_mod = sum[W:W-MW+1];
      endcase
   end

`ifdef JT51_MODBUF_SAT_EN
   localparam logic signed [W:0] SAT_HI = $signed((W+1)'((1 << (MW-1)) - 1));
   localparam logic signed [W:0] SAT_LO = ~SAT_HI;
`endif

   always_comb begin
      fbsum    = $signed(sext(fb0_q[rd_ch])) + $signed(sext(fb1_q[rd_ch]));
      fb_shamt = 4'd10 - {1'b0, bus.fb_II};
      fbsh     = fbsum >>> fb_shamt;
`ifdef JT51_MODBUF_SAT_EN
      if (fbsh > SAT_HI)
         fb_mod = {1'b0, {(MW-1){1'b1}}};
      else if (fbsh < SAT_LO)
         fb_mod = {1'b1, {(MW-1){1'b0}}};
      else
         fb_mod = fbsh[MW-1:0];
`else
      fb_mod = fbsh[MW-1:0];
`endif
      mod_next = (bus.m1_enters && bus.fb_II != 3'd0) ? fb_mod : sel_mod;
   end

   assign unused_bits = ^{sum[W-MW-1:0], fbsh[W:MW]};

   always_comb begin
      slot_d = slot_q;
      mod_d  = mod_q;
      hist_d = hist_q;
      x_d    = x_q;
      y_d    = y_q;
      fb0_d  = fb0_q;
      fb1_d  = fb1_q;
      if (bus.cen) begin
         slot_d    = bus.zero ? 5'd1 : slot_q + 5'd1;
         mod_d     = mod_next;
         hist_d[0] = bus.op_result;
         for (int i = 1; i < HL; i++) hist_d[i] = hist_q[i-1];
         if (wr_slot[4:3] == 2'd0) begin
            x_d[wr_ch]   = bus.op_result;
            fb1_d[wr_ch] = fb0_q[wr_ch];
            fb0_d[wr_ch] = bus.op_result;
         end
         if (wr_slot[4:3] == 2'd2) y_d[wr_ch] = bus.op_result;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_q <= '0;
         mod_q  <= '0;
         for (int i = 0; i < HL; i++) hist_q[i] <= '0;
         for (int i = 0; i < 8; i++) begin
            x_q[i]   <= '0;
            y_q[i]   <= '0;
            fb0_q[i] <= '0;
            fb1_q[i] <= '0;
         end
      end else begin
         slot_q <= slot_d;
         mod_q  <= mod_d;
         hist_q <= hist_d;
         x_q    <= x_d;
         y_q    <= y_d;
         fb0_q  <= fb0_d;
         fb1_q  <= fb1_d;
      end
   end
endmodule

// File: tb/tb_jt51_modbuf.sv
// Bench for jt51_modbuf: directed slot-by-slot stimulus, expected outputs queued per clock.
`timescale 1ns/1ps
module tb_jt51_modbuf;
   localparam logic [4:0] S_PP1 = 5'b10000;
   localparam logic [4:0] S_P2  = 5'b01000;
   localparam logic [4:0] S_P1  = 5'b00100;
   localparam logic [4:0] S_X   = 5'b00010;
   localparam logic [4:0] S_Y   = 5'b00001;
`ifdef JT51_MODBUF_SAT_EN
   localparam logic [9:0] SAT_EXP = 10'h1FF;
`else
   localparam logic [9:0] SAT_EXP = 10'h3FF;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [4:0] slot_m = '0;
   logic       zero_req = 1'b0;
   logic [15:0] exp_q[$];

   jt51_modbuf_if #(.W(14), .MW(10)) bus ();

   jt51_modbuf #(.W(14), .MW(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic [13:0] op, input logic [4:0] sel, input logic m1,
                        input logic [2:0] fb);
      bus.op_result = op;
      {bus.use_prevprev1, bus.use_prev2, bus.use_prev1, bus.use_internal_x,
       bus.use_internal_y} = sel;
      bus.m1_enters = m1;
      bus.fb_II     = fb;
   endtask

   // One clock: queue {check_mod, expected slot, expected mod_out} for the monitor.
   task automatic tick(input logic c, input logic chk, input logic [9:0] e);
      bus.cen  = c;
      bus.zero = (slot_m == 5'd0) || zero_req;
      if (c) slot_m = bus.zero ? 5'd1 : slot_m + 5'd1;
      exp_q.push_back({chk, slot_m, e});
      @(posedge clk);
      @(negedge clk);
      zero_req = 1'b0;
   endtask

   always begin : monitor
      logic [15:0] e;
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("slot", {11'd0, bus.slot}, {11'd0, e[14:10]});
         if (e[15]) check("mod_out", {6'd0, bus.mod_out}, {6'd0, e[9:0]});
      end
   end

   always @(posedge clk) begin
      if (!rst && bus.cen)
         assert (int'(bus.use_prevprev1) + int'(bus.use_prev2) + int'(bus.use_prev1) +
                 int'(bus.use_internal_x) + int'(bus.use_internal_y) <= 2)
         else $error("more than two modulation sources selected");
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [13:0] op;
      logic [4:0]  sel;
      logic        m1;
      logic [2:0]  fb;
      logic [9:0]  e;

      bus.cen = 1'b0;
      bus.zero = 1'b0;
      drive('0, '0, 1'b0, 3'd0);
      repeat (2) @(negedge clk);
      check("reset_slot", {11'd0, bus.slot}, 16'd0);
      check("reset_mod", {6'd0, bus.mod_out}, 16'd0);
      rst = 1'b0;

      // Round 1: taps, channel registers, first feedback writes.
      for (int s = 0; s < 32; s++) begin
         op = '0; sel = '0; m1 = 1'b0; fb = 3'd0; e = '0;
         case (s)
            0:  op = 14'h0400;
            1:  begin sel = S_P1; e = 10'h040; end
            4:  op = 14'h0100;
            5:  op = 14'h0800;
            6:  op = 14'h3000;
            7:  op = 14'h1FFF;
            12: op = 14'h0800;
            17: op = 14'h2000;
            20: begin sel = S_P2 | S_X; e = 10'h080; end
            24: begin sel = S_Y; e = 10'h200; end
            27: op = 14'h3000;
            28: begin sel = S_PP1 | S_P1; e = 10'h3C0; end
            default: ;
         endcase
         drive(op, sel, m1, fb);
         tick(1'b1, 1'b1, e);
      end

      // Round 2: second M1 outputs for channels 3, 5 and 6.
      for (int s = 0; s < 32; s++) begin
         op = '0;
         case (s)
            4: op = 14'h0100;
            6: op = 14'h3000;
            7: op = 14'h1FFF;
            default: ;
         endcase
         drive(op, '0, 1'b0, 3'd0);
         tick(1'b1, 1'b1, 10'h000);
      end

      // Round 3: feedback reads, cen gating, resync at slot 17.
      for (int s = 0; s < 18; s++) begin
         op = '0; sel = '0; m1 = 1'b0; fb = 3'd0; e = '0;
         case (s)
            3:  begin m1 = 1'b1; fb = 3'd7; sel = S_P1; e = 10'h040; end
            4:  begin op = 14'h0400; m1 = 1'b1; end
            5:  begin m1 = 1'b1; sel = S_P1; e = 10'h040; end
            6:  begin op = 14'h3000; m1 = 1'b1; fb = 3'd7; e = SAT_EXP; end
            10: op = 14'h0200;
            11: begin m1 = 1'b1; fb = 3'd1; e = 10'h002; end
            13: begin m1 = 1'b1; fb = 3'd4; e = 10'h380; end
            17: begin op = 14'h0C00; zero_req = 1'b1; end
            default: ;
         endcase
         drive(op, sel, m1, fb);
         tick(1'b1, 1'b1, e);
         if (s == 13) begin
            drive(14'h1234, S_P1 | S_X, 1'b1, 3'd5);
            repeat (5) tick(1'b0, 1'b1, 10'h380);
         end
      end
      drive('0, S_P1 | S_P2, 1'b0, 3'd0);
      tick(1'b1, 1'b1, 10'h070);

      // Asynchronous reset between clock edges.
      #2 rst = 1'b1;
      #1;
      check("async_rst_mod", {6'd0, bus.mod_out}, 16'd0);
      check("async_rst_slot", {11'd0, bus.slot}, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      slot_m = '0;

      drive(14'h1000, S_P1, 1'b0, 3'd0);  tick(1'b1, 1'b1, 10'h000);
      drive('0, S_P2, 1'b0, 3'd0);        tick(1'b1, 1'b1, 10'h000);
      drive('0, S_PP1, 1'b0, 3'd0);       tick(1'b1, 1'b1, 10'h000);
      drive('0, '0, 1'b1, 3'd7);          tick(1'b1, 1'b1, 10'h000);
      drive(14'h0400, S_X, 1'b0, 3'd0);   tick(1'b1, 1'b1, 10'h000);
      drive('0, S_P1, 1'b0, 3'd0);        tick(1'b1, 1'b1, 10'h040);

      bus.cen = 1'b0;
      drive('0, '0, 1'b0, 3'd0);
      repeat (2) @(negedge clk);
      check("queue_drain", 16'(exp_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/jt51_modbuf.md
Name: jt51_modbuf

Overview:
- Operator-output history buffer and phase-modulation builder.
- Sits between the operator output stage and the operator phase input.
- Each slot it records the operator result and builds that slot's 10-bit signed modulation from the per-slot select flags produced by the modulation-select logic.
- Also holds the per-channel M1 self-feedback history and applies the FB level.

Parameters:
- W, 14, operator result width (signed).
- MW, 10, modulation output width (signed).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cen  in  1  clock enable; one slot per cen cycle
- zero  in  1  high on the cen cycle of slot 0 (M1, ch0); resyncs the slot counter
- op_result  in  W  operator output for the slot that just left the operator stage (signed)
- fb_II  in  3  feedback level of the channel of the current slot; 0 = off
- m1_enters  in  1  current slot is M1
- use_prevprev1  in  1  select history tap PP1
- use_prev2  in  1  select history tap P2
- use_prev1  in  1  select history tap P1
- use_internal_x  in  1  select channel register X
- use_internal_y  in  1  select channel register Y
- mod_out  out  MW  phase modulation for the current slot (signed, registered)
- slot  out  5  internal slot counter (debug/verification)

Behaviour:
- All state advances only when cen=1; with cen=0 everything holds.
- Reset (async, any time including mid-cycle):
  - slot=0, mod_out=0.
  - History line, X/Y registers and both M1 feedback buffers cleared to 0.
- Slot counter:
  - When zero=1 on a cen cycle, slot:=1; otherwise slot:=slot+1 mod 32.
  - Channel ch = slot[2:0]; operator group = slot[4:3] (0=M1, 1=M2, 2=C1, 3=C2).
- History line: 24-entry shift register of W bits; op_result shifted in every cen.
  - P1 = entry delayed 1 slot.
  - P2 = entry delayed 8 slots.
  - PP1 = entry delayed 16 slots.
- Channel registers: 8 entries each, indexed by ch of the slot being written.
  - X written with op_result when the writing slot's group is M1.
  - Y written with op_result when the writing slot's group is C1.
  - Writing slot = slot-1.
- Modulation sum:
  - Selected sources are sign-extended to W+1 bits and added; n = number of active selects.
  - n=0: mod_out:=0.
  - n=1: mod_out := src[W-1:W-MW].
  - n=2: mod_out := sum[W:W-MW+1] (halved).
  - n>2 is illegal; the output is then don't-care, and the bench flags it as an assertion.
- M1 feedback, used when m1_enters=1 and fb_II≠0:
  - Modulation is taken from the feedback path and overrides all select inputs.
  - Per-channel registers FB0 (last M1 output) and FB1 (previous one); on an M1 write, FB1:=FB0 and FB0:=op_result.
  - fbsum = FB0+FB1 at W+1 bits.
  - fbmod = fbsum >>> (10-fb_II); low MW bits taken.
- fb_II=0 with m1_enters=1: normal select path applies (use_prev1 still works).
- Latency: mod_out registered one cen cycle after the slot's flags are presented.
- Simultaneous zero and cen: resync takes effect that same cycle; history is not cleared.

Optional Feature:
- Macro: JT51_MODBUF_SAT_EN.
- Defined: fbmod is saturated to [-2^(MW-1), 2^(MW-1)-1] before output.
- Undefined: fbmod wraps; MW low bits are taken only.

Test Plan:
- Reset mid-run: assert rst asynchronously between clk edges → mod_out=0 and slot=0 immediately; first read of P1/P2/PP1 after release is 0.
- Single tap: op_result=14'h0400 at slot s, use_prev1=1 at slot s+1 → mod_out=10'h040 one cen later.
- Two-source halve: P2=0x0800, X=0x0800, use_prev2=use_internal_x=1 → mod_out=0x080.
- Feedback, ch3 fb_II=7:
  - M1 outputs 0x0100 then 0x0100 → fbsum=0x200, fbmod=0x200>>>3=0x040.
  - fb_II=0 with no selects → 0.
- Saturation, fb_II=7, FB0=FB1=0x1FFF: with JT51_MODBUF_SAT_EN → mod_out=0x1FF; without → low 10 bits of 0x7FF = 0x3FF.
- cen gating and resync:
  - cen=0 for 5 clocks → slot and mod_out unchanged.
  - zero pulse at slot 17 → slot becomes 1 on that cen cycle; history contents are unaffected.
